// File: rtl/seg7_scan_param.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_param
// Purpose  : Multiplexed common-anode 7-segment scanner. Each digit slot
//            starts with a dark guard interval, then drives one digit with a
//            decoded snapshot of its BCD nibble and dp/blank/blink controls.
// Options  : SEG7_BLINK_EN - builds the frame-based blink counter and gating.
//            When undefined, blink_mask is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_param #(
  parameter int DIGITS       = 6,
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCAN_HZ      = 4_000,
  parameter int GUARD_CYC    = 64,
  parameter int BLINK_FRAMES = 333
) (
  input  logic                clk_50Mhz,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] bcd,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic [DIGITS-1:0]   blank_mask,
  input  logic [DIGITS-1:0]   blink_mask,
  output logic [7:0]          DIG_OUT,
  output logic [DIGITS-1:0]   SEL
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = $clog2(SCAN_DIV);
  localparam int IDX_W    = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END  = CNT_W'(GUARD_CYC);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             cnt_wrap;
  logic             enter_drive;
  logic [3:0]       nibble;
  logic [6:0]       seg;
  logic             dark;
  logic [7:0]       dig_next;

  assign cnt_wrap    = (cnt == CNT_LAST);
  assign cnt_next    = cnt_wrap ? '0 : cnt + 1'b1;
  assign idx_next    = cnt_wrap ? ((idx == IDX_LAST) ? '0 : idx + 1'b1) : idx;
  // The snapshot is taken on the edge that ends the guard interval.
  assign enter_drive = (cnt == GUARD_LAST);
  assign nibble      = bcd[{idx, 2'b00} +: 4];

`ifdef SEG7_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             phase_on;
  logic             frame_end;

  assign frame_end = cnt_wrap && (idx == IDX_LAST);

  // Count completed frames; flip the visible phase every BLINK_FRAMES frames.
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign dark = blank_mask[idx] | (blink_mask[idx] & ~phase_on);
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign dark         = blank_mask[idx];
`endif

  // BCD to active-low g..a; codes 10..15 show a dash.
  always_comb begin
    seg = 7'h3F;
    case (nibble)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h3F;
    endcase
  end

  // Blank wins over the decimal point.
  assign dig_next = dark ? 8'hFF : {~dp_mask[idx], seg};

  // Slot counter and digit index.
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      idx <= idx_next;
    end
  end

  // Registered outputs: dark during guard, latched snapshot during drive.
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      SEL     <= '1;
      DIG_OUT <= 8'hFF;
    end else if (cnt_next < GUARD_END) begin
      SEL     <= '1;
      DIG_OUT <= 8'hFF;
    end else if (enter_drive) begin
      SEL     <= ~(DIGITS'(1) << idx);
      DIG_OUT <= dig_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_param.md
# seg7_scan_param

- Parametrised multiplexed 7-segment scanner for the clock display path. Drives `DIGITS` common-anode digits from a packed BCD bus.
- Per-digit decimal point, blank and blink control; a guard interval blanks all digits before each new digit is driven, to suppress ghosting.
- Runs from the system 50 MHz clock with an internal scan prescaler. Sits between the time/setting logic and the board segment/select pins.

## Interface
- `DIGITS`, 6, number of digits scanned (2..8)
- `CLK_HZ`, 50_000_000, input clock frequency
- `SCAN_HZ`, 4_000, digit slot rate; `SCAN_DIV = CLK_HZ/SCAN_HZ` clocks per slot
- `GUARD_CYC`, 64, clocks of all-off at the start of each slot; must satisfy 1 ≤ `GUARD_CYC` < `SCAN_DIV`
- `BLINK_FRAMES`, 333, full scan frames per blink phase
- `clk_50Mhz` in 1: system clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `bcd` in 4*DIGITS: digit i at bits [4i+3:4i]; digit 0 is the rightmost
- `dp_mask` in DIGITS: 1 = light the decimal point of digit i
- `blank_mask` in DIGITS: 1 = digit i dark
- `blink_mask` in DIGITS: 1 = digit i blinks
- `DIG_OUT` out 8: active-low segments; bit7 = dp, bits[6:0] = g..a
- `SEL` out DIGITS: active-low one-hot digit select

## Operation
- Slot counter `cnt` runs 0..SCAN_DIV-1 and wraps to 0.
- Digit index `idx` runs 0..DIGITS-1. It advances on the edge where `cnt` wraps, and wraps from DIGITS-1 to 0.
- Guard phase, `cnt` < GUARD_CYC:
  - `SEL` is all ones.
  - `DIG_OUT` = 8'hFF.
- Drive phase, `cnt` ≥ GUARD_CYC:
  - `SEL[idx]` = 0; all other `SEL` bits = 1.
  - `DIG_OUT` holds the decoded snapshot.
- Snapshot: `bcd` nibble, `dp_mask`, `blank_mask` and `blink_mask` bits for `idx` are captured on the edge where `cnt` goes GUARD_CYC-1 → GUARD_CYC. Input changes during the drive phase do not affect the current slot.
- Segment decode, active-low (bit7 = 1 here, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90
  - 10..15 display "-", code BF
- The dp bit is cleared (lit) when the snapshot dp bit is 1.
- Digit is dark (`DIG_OUT` = FF, `SEL` still asserted) when:
  - the blank bit is set, or
  - the blink bit is set while blink phase = off.
- Blank overrides dp.
- Frame = DIGITS slots; frame end is the edge where `idx` wraps to 0.
  - Blink counter counts frames. Blink phase toggles every BLINK_FRAMES frames.
  - Reset phase = on (visible).

## Timing
- All outputs are registered and change on the same edge as `cnt`. There is no combinational path from inputs to outputs.
- Reset values (asynchronous):
  - `SEL` = all ones, `DIG_OUT` = 8'hFF
  - `cnt` = 0, `idx` = 0, blink counter = 0, phase = on
- After release, the first clock edge gives `cnt` = 1. Digit 0 is first driven on the edge entering `cnt` = GUARD_CYC.
- Per slot: GUARD_CYC clocks dark, then SCAN_DIV-GUARD_CYC clocks driven. A full frame is DIGITS*SCAN_DIV clocks.
- Reset asserted mid-slot: outputs go to reset values immediately, without waiting for a clock. Scan restarts at digit 0.
- Blink toggle and `idx` wrap on the same edge: the new phase applies from the next snapshot.

## Configuration
- `SEG7_BLINK_EN` defined: blink counter and blink gating are present as described above.
- `SEG7_BLINK_EN` undefined:
  - blink counter is not built;
  - `blink_mask` is ignored;
  - digits are dark only through `blank_mask`.

## Test plan
All scenarios use DIGITS=4, CLK_HZ=1000, SCAN_HZ=100 (SCAN_DIV=10), GUARD_CYC=2, BLINK_FRAMES=2.
- Reset release:
  - Stimulus: `bcd`=16'h1234, all masks 0.
  - Response: cycles 0–1 `SEL`=F, `DIG_OUT`=FF; cycles 2–9 `SEL`=E, `DIG_OUT`=99; cycles 12–19 `SEL`=D, `DIG_OUT`=B0; after `SEL`=7 (digit 3, `DIG_OUT`=F9), returns to `SEL`=E.
- Decode sweep:
  - Stimulus: digit 0 nibble set to 0..15 on successive frames.
  - Response: codes C0,F9,A4,B0,99,92,82,F8,80,90, then BF for 10–15.
- dp/blank:
  - Stimulus: `dp_mask`=4'b0010, `blank_mask`=4'b0100, `bcd`=16'h8888.
  - Response: digit 1 `DIG_OUT`=00; digit 2 `DIG_OUT`=FF with `SEL`=B; digits 0 and 3 = 80.
- Snapshot:
  - Stimulus: change digit 0 from 3 to 5 at `cnt`=5.
  - Response: `DIG_OUT` stays B0 through `cnt`=9; the next digit-0 slot shows 92.
- Blink (macro defined):
  - Stimulus: `blink_mask`=4'b0001.
  - Response: digit 0 lit in frames 0–1, dark in 2–3, lit in 4–5; other digits always lit. With the macro undefined, always lit.
- Async reset:
  - Stimulus: assert `rst_n`=0 between edges during a drive phase.
  - Response: `SEL`=F and `DIG_OUT`=FF before the next edge.
